// File: rtl/div_pipe_scheduler.sv
// Issue/retire scheduler for the fixed-latency pipelined divider: tracks in-flight
// divides in a shift register, raises decode stalls and tags writeback results.
module div_pipe_scheduler #(
    parameter int unsigned DIV_LATENCY  = 8,
    parameter int unsigned MAX_INFLIGHT = 8,
    parameter int unsigned CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [1:0]       issue_op,
    input  logic [4:0]       issue_rd,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       id_rd,
    input  logic             id_rd_we,
    input  logic             flush,
    output logic             div_start,
    output logic [1:0]       div_op,
    output logic             stall_id,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic [1:0]       wb_op,
    output logic             wb_claim_next,
    output logic [CNT_W-1:0] inflight_cnt,
    output logic             idle
);

    logic [DIV_LATENCY-1:0]      vld_q, vld_d;
    logic [DIV_LATENCY-1:0][4:0] rd_q,  rd_d;
    logic [DIV_LATENCY-1:0][1:0] op_q,  op_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;

    logic raw_hit;
    logic waw_hit;
    logic cap_stall;
    logic retire;

    assign retire = vld_q[DIV_LATENCY-1];

    // x0 entries are tracked but never match; the last entry still counts as in flight.
    always_comb begin
        raw_hit = 1'b0;
        waw_hit = 1'b0;
        for (int unsigned i = 0; i < DIV_LATENCY; i++) begin
            if (vld_q[i] && (rd_q[i] != 5'd0)) begin
                if ((id_rs1_used && (rd_q[i] == id_rs1)) ||
                    (id_rs2_used && (rd_q[i] == id_rs2)))
                    raw_hit = 1'b1;
                if (id_rd_we && (rd_q[i] == id_rd))
                    waw_hit = 1'b1;
            end
        end
    end

    // A retirement in the same cycle frees a slot, so a full tracker may still accept.
    assign cap_stall = issue_valid && (cnt_q == CNT_W'(MAX_INFLIGHT)) && !retire;
    assign stall_id  = (raw_hit || waw_hit || cap_stall) && !flush;
    assign div_start = issue_valid && !stall_id && !flush;
    assign div_op    = issue_op;

    always_comb begin
        vld_d = {vld_q[DIV_LATENCY-2:0], div_start};
        rd_d  = {rd_q[DIV_LATENCY-2:0],  issue_rd};
        op_d  = {op_q[DIV_LATENCY-2:0],  issue_op};
        cnt_d = cnt_q + CNT_W'(div_start) - CNT_W'(retire);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            rd_q  <= '0;
            op_q  <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            rd_q  <= rd_d;
            op_q  <= op_d;
            cnt_q <= cnt_d;
        end
    end

    assign wb_valid      = vld_q[DIV_LATENCY-1];
    assign wb_rd         = rd_q[DIV_LATENCY-1];
    assign wb_op         = op_q[DIV_LATENCY-1];
    assign wb_claim_next = vld_q[DIV_LATENCY-2];
    assign inflight_cnt  = cnt_q;
    assign idle          = (cnt_q == '0);

endmodule
